// File: rtl/dmem_pkg.sv
// Shared constants for the byte-addressable data memory: funct3 codes, FSM
// states and the store byte-enable / legality helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Stores only have signed-looking encodings; BU/HU are load-only.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic [BE_W-1:0] byte_enable(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Combinational load lane extraction with sign or zero extension by funct3.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign shifted   = word >> {lane, 3'b000};
  assign lane_byte = shifted[7:0];
  assign lane_half = shifted[15:0];

  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = {{24{lane_byte[7]}}, lane_byte};
      F3_H:    result = {{16{lane_half[15]}}, lane_half};
      F3_W:    result = word;
      F3_BU:   result = {24'h0, lane_byte};
      F3_HU:   result = {16'h0, lane_half};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressable RV32 data memory: one-cycle request/response, sub-word
// loads and stores, alignment/range checks and a post-reset clear sequence.
module byte_data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int MEMORY_DEPTH   = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_error_o,
  output logic                  init_done_o
);

  localparam int IDX_W = $clog2(MEMORY_DEPTH);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] clr_cnt;
  logic             clr_we;

  logic [IDX_W-1:0]      idx;
  logic [1:0]            lane;
  logic [ADDR_WIDTH-1:0] hi_bits;
  logic                  misaligned;
  logic                  err;
  logic                  accept;
  logic                  wr_en;
  logic [BE_W-1:0]       be;
  logic [31:0]           wdata_rep;

  logic             vld_p1;
  logic             err_p1;
  logic             load_p1;
  logic [1:0]       lane_p1;
  logic [2:0]       f3_p1;
  logic [31:0]      word_p1;
  logic [31:0]      load_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (clr_we) clr_cnt <= clr_cnt + IDX_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    clr_we     = 1'b0;
    case (state)
      ST_INIT: begin
        if (CLEAR_ON_RESET) begin
          clr_we = 1'b1;
          if (clr_cnt == IDX_W'(MEMORY_DEPTH - 1)) state_next = ST_RUN;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  assign req_ready_o = (state == ST_RUN);
  assign init_done_o = (state == ST_RUN);

  // Request decode and checks (p0)
  assign idx     = req_addr_i[IDX_W+1:2];
  assign lane    = req_addr_i[1:0];
  assign hi_bits = req_addr_i >> (IDX_W + 2);

  assign misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                      ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
  assign err    = !f3_legal(req_we_i, req_funct3_i) || misaligned || (|hi_bits);
  assign accept = req_valid_i && req_ready_o;
  assign wr_en  = accept && req_we_i && !err;
  assign be     = byte_enable(req_funct3_i, lane);

  always_comb begin
    wdata_rep = req_wdata_i;
    case (req_funct3_i[1:0])
      2'b00:   wdata_rep = {4{req_wdata_i[7:0]}};
      2'b01:   wdata_rep = {2{req_wdata_i[15:0]}};
      default: wdata_rep = req_wdata_i;
    endcase
  end

  // Storage and synchronous read into p1
  for (genvar b = 0; b < BE_W; b++) begin : g_bank
    logic [7:0] mem [MEMORY_DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (clr_we) mem[clr_cnt] <= '0;
      else if (wr_en && be[b]) mem[idx] <= wdata_rep[8*b +: 8];
      rd_q <= mem[idx];
    end

    assign word_p1[8*b +: 8] = rd_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
      load_p1 <= 1'b0;
    end else begin
      vld_p1  <= accept;
      err_p1  <= accept && err;
      load_p1 <= accept && !req_we_i && !err;
    end
  end

  always_ff @(posedge clk_i) begin
    lane_p1 <= lane;
    f3_p1   <= req_funct3_i;
  end

  // Response (p1)
  dmem_load_align u_align (
    .word   (word_p1),
    .lane   (lane_p1),
    .funct3 (f3_p1),
    .result (load_data)
  );

  assign rsp_valid_o = vld_p1;
  assign rsp_error_o = err_p1;
  assign rsp_rdata_o = load_p1 ? load_data : 32'h0;

endmodule

// File: tb/tb_byte_data_memory.sv
// Bench for byte_data_memory: byte-level reference model with a per-cycle
// compare process, directed literal cases and a randomized phase.
module tb_byte_data_memory;

  localparam int AW     = 32;
  localparam int DEPTH  = 64;
  localparam int NBYTES = DEPTH * 4;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_error;
  logic          init_done;

  always #5 clk = ~clk;

  byte_data_memory #(
    .ADDR_WIDTH     (AW),
    .MEMORY_DEPTH   (DEPTH),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_error_o  (rsp_error),
    .init_done_o  (init_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endfunction

  // Reference model: byte array plus a count of clock edges since reset.
  logic [7:0]  mmem [NBYTES];
  int          rcnt = 0;
  bit          exp_vld = 1'b0;
  bit          exp_err = 1'b0;
  logic [31:0] exp_rdata = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      rcnt = 0; exp_vld = 0; exp_err = 0; exp_rdata = '0;
      foreach (mmem[i]) mmem[i] = 8'h00;
    end else begin
      exp_vld = req_valid && (rcnt >= DEPTH);
      exp_err = 1'b0;
      exp_rdata = '0;
      if (exp_vld) begin
        longint unsigned a;
        int size;
        bit legal;
        logic [31:0] v;
        a = req_addr;
        size = (req_funct3[1:0] == 2'b00) ? 1 : (req_funct3[1:0] == 2'b01) ? 2 : 4;
        legal = req_we ? (req_funct3 inside {LB, LH, LW})
                       : (req_funct3 inside {LB, LH, LW, LBU, LHU});
        if (!legal || (a % longint'(size) != 0) || a >= NBYTES) begin
          exp_err = 1'b1;
        end else if (req_we) begin
          for (int i = 0; i < size; i++) mmem[int'(a) + i] = req_wdata[8*i +: 8];
        end else begin
          v = '0;
          for (int i = 0; i < size; i++) v = v | (32'(mmem[int'(a) + i]) << (8*i));
          if (!req_funct3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
          exp_rdata = v;
        end
      end
      if (rcnt < DEPTH) rcnt++;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("ready", 32'(req_ready), 32'(rcnt >= DEPTH && !rst));
    chk("init_done", 32'(init_done), 32'(rcnt >= DEPTH && !rst));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld && !rst));
    if (exp_vld && !rst) begin
      chk("rsp_error", 32'(rsp_error), 32'(exp_err));
      chk("rsp_rdata", rsp_rdata, exp_rdata);
    end
  end

  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rd = rsp_rdata;
    er = rsp_error;
  endtask

  task automatic check_clear_timing(input string name);
    repeat (DEPTH - 1) @(negedge clk);
    chk({name, "_ready_low"}, 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    chk({name, "_ready_high"}, 32'(req_ready), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_init_done", 32'(init_done), 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_error", 32'(rsp_error), 32'd0);
    rst = 1'b0;
    check_clear_timing("first_clear");

    req(0, LW, 32'h10, 0, rd, er);             chk("lw_after_clear", rd, 32'h0);

    req(1, LW, 32'h20, 32'hDEADBEEF, rd, er);
    req(0, LB, 32'h23, 0, rd, er);             chk("lb_23", rd, 32'hFFFFFFDE);
    req(0, LBU, 32'h21, 0, rd, er);            chk("lbu_21", rd, 32'h000000BE);
    req(0, LH, 32'h22, 0, rd, er);             chk("lh_22", rd, 32'hFFFFDEAD);
    req(0, LHU, 32'h20, 0, rd, er);            chk("lhu_20", rd, 32'h0000BEEF);

    req(1, LW, 32'h40, 32'h11223344, rd, er);
    req(1, LB, 32'h41, 32'h123456AA, rd, er);
    req(1, LH, 32'h42, 32'hABCD5566, rd, er);
    req(0, LW, 32'h40, 0, rd, er);             chk("sub_word_merge", rd, 32'h5566AA44);

    req(0, LW, 32'h42, 0, rd, er);             chk("lw_mis_err", 32'(er), 1); chk("lw_mis_rdata", rd, 0);
    req(1, LH, 32'h41, 32'hFFFFFFFF, rd, er);  chk("sh_mis_err", 32'(er), 1);
    req(0, LW, 32'h40, 0, rd, er);             chk("sh_mis_no_write", rd, 32'h5566AA44);
    req(0, LW, NBYTES, 0, rd, er);             chk("lw_range_err", 32'(er), 1);
    req(0, 3'b011, 32'h40, 0, rd, er);         chk("f3_011_err", 32'(er), 1);
    req(1, LBU, 32'h40, 32'h0, rd, er);        chk("sbu_err", 32'(er), 1);

    req_valid = 1'b1; req_we = 1'b1; req_funct3 = LW; req_addr = 32'h80; req_wdata = 32'h12345678;
    @(posedge clk); @(negedge clk);
    chk("b2b_store_valid", 32'(rsp_valid), 1);
    req_we = 1'b0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_load_valid", 32'(rsp_valid), 1);
    chk("b2b_load_data", rsp_rdata, 32'h12345678);

    rst = 1'b1; @(negedge clk); rst = 1'b0;
    repeat (DEPTH / 2) @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = LW; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
    check_clear_timing("restart_clear");
    for (int w = 0; w < DEPTH; w++) begin
      req(0, LW, 32'(w * 4), 0, rd, er);
      chk("cleared_word", rd, 32'h0);
    end

    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) begin
        req_valid = 1'b0;
        rst = 1'b1; @(negedge clk); @(negedge clk); rst = 1'b0;
      end
      req_valid  = ($urandom_range(0, 3) != 0);
      req_we     = $urandom_range(0, 1) == 1;
      req_funct3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) req_addr = $urandom;
      else if ($urandom_range(0, 3) != 0) req_addr = 32'($urandom_range(0, 31));
      else req_addr = 32'($urandom_range(0, NBYTES - 1));
      req_wdata = $urandom;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
